mem_responder: RTL



---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_bank.sv | 81 ++++++++
 rtl/mem_responder.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, bank-state encoding and address helpers
//
// Purpose: common definitions for the four-way word-interleaved memory
// responder. Byte address layout: [15:3] row, [2:1] bank, [0] must be 0.
// Ports: none (package).
package mem_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int ROW_W     = 13;
  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = 2;
  localparam int BUSY_CYC  = 4;
  localparam int RD_LAT    = 2;

  // Bank occupancy state; the encoding doubles as the remaining-busy count,
  // so B3 is the BUSY_CYC-1 load value taken on accept.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } bank_state_e;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    logic unused_bits;
    // Row and byte-offset bits play no part in bank selection.
    unused_bits = ^{addr[ADDR_W-1:3], addr[0]};
    return addr[2:1];
  endfunction

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - one memory bank: row array, occupancy FSM, registered read
//
// Purpose: holds 2**ROW_W words. An accepted access occupies the bank for
// BUSY_CYC cycles including the accept cycle. Writes commit at the accept
// edge; reads capture the addressed word into rdata at the accept edge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   acc         access accepted this cycle (only when bank idle)
//   we          1 = write, 0 = read (meaningful with acc)
//   row         row index
//   wdata       write data
//   busy        bank occupied (B3/B2/B1)
//   rdata       word captured by the most recent accepted read
module mem_bank
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata
);

  bank_state_e       state_q, state_d;
  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: countdown after accept, no early release
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = B3;
      B3:      state_d = B2;
      B2:      state_d = B1;
      B1:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Array contents survive reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (acc && we) begin
      mem_q[row] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (acc && !we) begin
      rdata_d = mem_q[row];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - banked memory responder for the cache memory port
//
// Purpose: four-way word-interleaved memory with 2-cycle read latency and
// 4-cycle bank occupancy. Consecutive words land in different banks, so a
// 4-word line fill/writeback streams one word per cycle without stall.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   addr        byte address (bit 0 must be 0)
//   data_in     write data
//   wr, rd      request strobes (exactly one for a legal request)
//   data_out    read data during the RD_LAT-th cycle after accept, else 0
//   stall       legal request hitting a busy bank; requester must hold it
//   busy        per-bank occupied flags
//   err         one-cycle pulse the cycle after an illegal request
module mem_responder
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  logic                 req;
  logic                 legal;
  logic                 accept;
  logic [BANK_W-1:0]    bank;
  logic [ROW_W-1:0]     row;
  logic [NUM_BANKS-1:0] bank_acc;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  logic                 err_q, err_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [BANK_W-1:0]    s1_bank_q, s1_bank_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]    s2_data_q, s2_data_d;

  always_comb begin
    bank   = bank_of(addr);
    row    = addr[ADDR_W-1:3];
    req    = wr | rd;
    legal  = (wr ^ rd) & ~addr[0];
    // Illegal requests never stall; they are simply dropped and flagged.
    stall  = legal & busy[bank];
    accept = legal & ~busy[bank];

    bank_acc       = '0;
    bank_acc[bank] = accept;

    err_d = req & ~legal;

    // Stage 1 lives in the bank (rdata); here we only track which bank
    // holds a valid read so stage 2 can pick it up a cycle later.
    s1_valid_d = accept & rd;
    s1_bank_d  = bank;

    s2_valid_d = s1_valid_q;
    s2_data_d  = s1_valid_q ? bank_rdata[s1_bank_q] : '0;

    data_out = s2_valid_q ? s2_data_q : '0;
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    mem_bank u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .acc   (bank_acc[i]),
      .we    (wr),
      .row   (row),
      .wdata (data_in),
      .busy  (busy[i]),
      .rdata (bank_rdata[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_bank_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_bank_q  <= s1_bank_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign err = err_q;

endmodule
